// File: rtl/output_reader_pkg.sv
// Shared types and constants for the Output SRAM drain engine.
package output_reader_pkg;

    localparam int unsigned BANK_WORDS  = 32768;
    localparam int unsigned NUM_BANKS   = 6;
    localparam int unsigned TOTAL_WORDS = BANK_WORDS * NUM_BANKS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]  bank;
        logic [14:0] offset;
    } addr_t;

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry FIFO between the SRAM read return and the output stream.
module reader_skid_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign dout  = mem[rd_ptr];

    // The issue throttle upstream guarantees these never fire.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2));
    assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0));

endmodule

// File: rtl/output_sram_reader.sv
// Output SRAM drain engine: streams the low byte of sequential words across banks.
// Build option OUT_CHECKSUM_EN adds a running signed checksum of streamed elements.
module output_sram_reader
    import output_reader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 18,
    parameter int LEN_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [2:0]        sram_bank_o,
    output logic [14:0]       sram_addr_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              m_valid_o,
    output logic [OUT_W-1:0]  m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [31:0]       checksum_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // CHECK | one cycle: reject empty or out-of-range transfers
    // READ  | issuing sequential reads
    // DRAIN | all reads issued, waiting for pipeline and FIFO to empty
    // DONE  | one-cycle done_o (and err_o) pulse

    localparam int SUM_W = LEN_W + 1;

    state_t           state, state_nxt;
    addr_t            addr_q;
    addr_t            addr_inc;
    logic [LEN_W-1:0] remaining;
    logic             inflight;
    logic             inflight_last;
    logic             err_q;
    logic             set_err;
    logic             issue;
    logic             pop;
    logic             slots_free;
    logic             range_bad;
    logic             start_acc;
    logic [1:0]       fifo_count;
    logic [SUM_W-1:0] end_addr;
    wire              unused_rdata_hi = ^sram_rdata_i[DATA_W-1:OUT_W];

    assign start_acc = (state == ST_IDLE) && start_i;
    assign pop       = m_valid_o & m_ready_i;
    // Throttle so the FIFO plus the outstanding read never exceed two entries.
    assign slots_free = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign end_addr   = SUM_W'({addr_q.bank, addr_q.offset}) + SUM_W'(remaining);
    assign range_bad  = end_addr > SUM_W'(TOTAL_WORDS);

    always_comb begin
        addr_inc = addr_q;
        if (addr_q.offset == 15'h7FFF) begin
            addr_inc.offset = 15'd0;
            addr_inc.bank   = addr_q.bank + 3'd1;
        end else begin
            addr_inc.offset = addr_q.offset + 15'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue && (remaining == LEN_W'(1));
            if (start_acc) begin
                addr_q    <= addr_t'(base_addr_i);
                remaining <= len_i;
                err_q     <= 1'b0;
            end else begin
                if (set_err) begin
                    err_q <= 1'b1;
                end
                if (issue) begin
                    remaining <= remaining - LEN_W'(1);
                    addr_q    <= addr_inc;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        set_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (remaining == '0) begin
                    state_nxt = ST_DONE;
                end else if (range_bad) begin
                    set_err   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                issue = (remaining != '0) && slots_free;
                if (issue && remaining == LEN_W'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as soon as the final element is being handed off.
                if (!inflight && fifo_count == {1'b0, pop}) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    reader_skid_fifo #(
        .W(OUT_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({inflight_last, sram_rdata_i[OUT_W-1:0]}),
        .pop   (pop),
        .valid (m_valid_o),
        .dout  ({m_last_o, m_data_o}),
        .count (fifo_count)
    );

    assign busy_o      = (state != ST_IDLE);
    assign done_o      = (state == ST_DONE);
    assign err_o       = (state == ST_DONE) && err_q;
    assign sram_cs_o   = issue;
    assign sram_oe_o   = issue;
    assign sram_bank_o = issue ? addr_q.bank : 3'd0;
    assign sram_addr_o = issue ? addr_q.offset : 15'd0;

`ifdef OUT_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= 32'd0;
        end else if (start_acc) begin
            checksum_q <= 32'd0;
        end else if (pop) begin
            checksum_q <= checksum_q + {{(32-OUT_W){m_data_o[OUT_W-1]}}, m_data_o};
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'd0;
`endif

endmodule
